fetch_unit: RTL and testbench

Parametrised instruction prefetch unit for the next-generation RV32 core. It owns the fetch PC and issues word reads over the shared memory handshake (exec/busy/fin). It buffers up to DEPTH fetched instructions with their PCs in a queue and hands them to the execute side via valid/ready. A redirect (branch, jump, trap) flushes the queue. Any in-flight memory read is completed and its data discarded.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   localparam logic [2:0] SEL_WORD = 3'b010;
   localparam int         INSTR_W  = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} entries; head is read straight from storage.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic             pop_ok;
   logic [CW-1:0]    count_n;

   // Popping an empty queue is silently ignored.
   assign pop_ok = pop && valid;

   always_comb begin
      count_n = count;
      if (clear)
         count_n = '0;
      else if (push && !pop_ok)
         count_n = count + CW'(1);
      else if (!push && pop_ok)
         count_n = count - CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= 1'b0;
      end else begin
         count <= count_n;
         valid <= (count_n != '0);
         if (clear) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (push)   tail <= tail + PW'(1);
            if (pop_ok) head <= head + PW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !clear) begin
         mem[tail] <= din;
      end
   end

   assign dout = mem[head];

   push_not_full: assert property (@(posedge i_clk) disable iff (i_reset)
      (push && !clear) |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction prefetch: one outstanding word read at a time, results queued for execute.
//
// state     | meaning
// S_IDLE    | no read outstanding; issue when enabled, memory free and queue has room
// S_WAIT    | read outstanding; its data is pushed on fin
// S_DISCARD | read outstanding but redirected away; its data is dropped on fin
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_enable,
   input  logic                     i_redirect,
   input  logic [XLEN-1:0]          i_redirect_pc,
   output logic                     o_valid,
   output logic [INSTR_W-1:0]       o_instr,
   output logic [XLEN-1:0]          o_pc,
   input  logic                     i_ready,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_mem_exec,
   output logic [XLEN-1:0]          o_mem_addr,
   output logic                     o_mem_we,
   output logic [2:0]               o_mem_sel,
   input  logic                     i_mem_busy,
   input  logic                     i_mem_fin,
   input  logic [INSTR_W-1:0]       i_mem_data
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t                    state;
   logic [XLEN-1:0]           fetch_pc;
   logic                      issue;
   logic                      push;
   logic [XLEN+INSTR_W-1:0]   head;
   logic                      unused_pc_bits;

   assign unused_pc_bits = ^i_redirect_pc[1:0];

   assign issue = (state == S_IDLE) && i_enable && !i_mem_busy && !i_redirect
                  && (o_count < CW'(DEPTH));
   assign push  = (state == S_WAIT) && i_mem_fin && !i_redirect;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= S_IDLE;
         fetch_pc   <= RESET_PC;
         o_mem_exec <= 1'b0;
         o_mem_addr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue) begin
                  o_mem_exec <= 1'b1;
                  o_mem_addr <= fetch_pc;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_mem_fin) begin
                  o_mem_exec <= 1'b0;
                  state      <= S_IDLE;
                  if (!i_redirect) fetch_pc <= fetch_pc + XLEN'(4);
               end else if (i_redirect) begin
                  state <= S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (i_mem_fin) begin
                  o_mem_exec <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         // Redirect overrides the post-fin increment above.
         if (i_redirect) fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      end
   end

   assign o_mem_we  = 1'b0;
   assign o_mem_sel = SEL_WORD;

   fetch_fifo #(
      .WIDTH (XLEN + INSTR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .clear   (i_redirect),
      .push    (push),
      .pop     (i_ready),
      .din     ({fetch_pc, i_mem_data}),
      .dout    (head),
      .valid   (o_valid),
      .count   (o_count)
   );

   assign o_pc    = head[XLEN+INSTR_W-1:INSTR_W];
   assign o_instr = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: responder model, in-order stream model, directed + random stimulus.
module tb_fetch_unit;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_enable = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_valid;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        i_ready = 1'b0;
   logic [2:0]  o_count;
   logic        o_mem_exec;
   logic [31:0] o_mem_addr;
   logic        o_mem_we;
   logic [2:0]  o_mem_sel;
   logic        i_mem_busy = 1'b0;
   logic        i_mem_fin;
   logic [31:0] i_mem_data;

   fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_enable      (i_enable),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_valid       (o_valid),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .i_ready       (i_ready),
      .o_count       (o_count),
      .o_mem_exec    (o_mem_exec),
      .o_mem_addr    (o_mem_addr),
      .o_mem_we      (o_mem_we),
      .o_mem_sel     (o_mem_sel),
      .i_mem_busy    (i_mem_busy),
      .i_mem_fin     (i_mem_fin),
      .i_mem_data    (i_mem_data)
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Memory responder: fin arrives lat cycles after it first sees exec.
   int          lat = 1;
   bit          pend = 0;
   int          wcnt = 0;
   logic [31:0] raddr = '0;

   initial begin
      i_mem_fin  = 1'b0;
      i_mem_data = '0;
      forever begin
         @(posedge i_clk);
         #2;
         i_mem_fin = 1'b0;
         if (i_reset) begin
            pend = 0;
         end else if (pend) begin
            if (wcnt <= 1) begin
               i_mem_fin  = 1'b1;
               i_mem_data = raddr ^ KEY;
               pend       = 0;
            end else begin
               wcnt--;
            end
         end else if (o_mem_exec) begin
            pend  = 1;
            raddr = o_mem_addr;
            wcnt  = lat;
         end
      end
   end

   // Reference model: the consumer sees a contiguous word stream from the last
   // restart PC; a read in flight at a redirect is dropped.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q[$];
   bit          outstanding = 0;
   bit          stale = 0;
   bit          prev_reset = 0;
   bit          expect_issue = 0;
   bit          new_req;
   logic [31:0] model_pc = RESET_PC;
   logic [31:0] req_a = '0;
   int          cnt0;

   always @(negedge i_clk) begin
      if (prev_reset) begin
         check("rst_exec",  32'(o_mem_exec), 32'd0);
         check("rst_addr",  o_mem_addr,      32'd0);
         check("rst_valid", 32'(o_valid),    32'd0);
         check("rst_count", 32'(o_count),    32'd0);
         check("rst_instr", o_instr,         32'd0);
         check("rst_pc",    o_pc,            32'd0);
      end
      if (i_reset) begin
         q.delete();
         outstanding  = 0;
         stale        = 0;
         model_pc     = RESET_PC;
         expect_issue = 0;
         prev_reset   = 1;
      end else begin
         prev_reset = 0;
         cnt0 = q.size();
         check("count", 32'(o_count), 32'(cnt0));
         check("valid", 32'(o_valid), 32'(cnt0 != 0));
         check("mem_we", 32'(o_mem_we), 32'd0);
         check("mem_sel", 32'(o_mem_sel), 32'd2);
         new_req = o_mem_exec && !outstanding;
         check("issue", 32'(new_req), 32'(expect_issue));
         if (new_req) begin
            check("req_addr", o_mem_addr, model_pc);
            outstanding = 1;
            req_a       = model_pc;
         end else if (outstanding) begin
            check("exec_hold", 32'(o_mem_exec), 32'd1);
         end
         if (o_valid && i_ready && q.size() > 0) begin
            check("head_pc", o_pc, q[0].pc);
            check("head_instr", o_instr, q[0].ins);
            void'(q.pop_front());
         end
         expect_issue = !outstanding && i_enable && !i_mem_busy && !i_redirect && (cnt0 < DEPTH);
         if (i_mem_fin && outstanding) begin
            outstanding = 0;
            if (!stale && !i_redirect) begin
               q.push_back('{pc: req_a, ins: req_a ^ KEY});
               model_pc = model_pc + 32'd4;
            end
            stale = 0;
         end
         if (i_redirect) begin
            q.delete();
            if (outstanding) stale = 1;
            model_pc = {i_redirect_pc[31:2], 2'b00};
         end
      end
   end

   task automatic wait_exec(input logic level, input int budget, input string name);
      int n = 0;
      while (o_mem_exec !== level && n < budget) begin
         step();
         n++;
      end
      check(name, 32'(o_mem_exec), 32'(level));
   endtask

   task automatic wait_count(input int val, input int budget, input string name);
      int n = 0;
      while (int'(o_count) != val && n < budget) begin
         step();
         n++;
      end
      check(name, 32'(o_count), 32'(val));
   endtask

   initial begin
      int seen;
      i_reset = 1'b1;
      step();
      step();
      i_reset = 1'b0;

      // Fill to DEPTH with a one-cycle memory, then issue must stop.
      lat = 1;
      i_enable = 1'b1;
      wait_count(4, 40, "fill_count");
      repeat (4) step();
      check("full_count", 32'(o_count), 32'd4);
      check("full_no_exec", 32'(o_mem_exec), 32'd0);

      // One pop frees one slot: exactly one read, to 16.
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      wait_exec(1'b1, 10, "refill_exec");
      check("refill_addr", o_mem_addr, 32'd16);
      wait_count(4, 10, "refill_count");

      // Redirect during a slow read: exec held, data dropped, restart at 0x100.
      lat = 5;
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      wait_exec(1'b1, 10, "slow_exec");
      step();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_0102;
      step();
      i_redirect = 1'b0;
      check("redir_count", 32'(o_count), 32'd0);
      check("redir_exec_held", 32'(o_mem_exec), 32'd1);
      wait_exec(1'b0, 10, "discard_done");
      wait_exec(1'b1, 10, "redir_exec");
      check("redir_addr", o_mem_addr, 32'h0000_0100);

      // Redirect coinciding with fin: no push, restart at the new PC.
      lat = 1;
      wait_exec(1'b0, 10, "pre_coin_idle");
      wait_exec(1'b1, 10, "pre_coin_exec");
      step();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_2000;
      step();
      i_redirect = 1'b0;
      check("coin_count", 32'(o_count), 32'd0);
      wait_exec(1'b1, 10, "coin_exec");
      check("coin_addr", o_mem_addr, 32'h0000_2000);

      // Busy blocks issue; request goes out the cycle after busy drops.
      i_enable = 1'b0;
      i_ready = 1'b1;
      wait_exec(1'b0, 10, "drain_idle");
      repeat (4) step();
      check("drain_count", 32'(o_count), 32'd0);
      i_ready = 1'b0;
      i_mem_busy = 1'b1;
      i_enable = 1'b1;
      seen = 0;
      repeat (10) begin
         step();
         if (o_mem_exec) seen++;
      end
      check("busy_block", 32'(seen), 32'd0);
      i_mem_busy = 1'b0;
      step();
      check("busy_release", 32'(o_mem_exec), 32'd1);

      // Reset in the middle of a read.
      lat = 5;
      step();
      i_reset = 1'b1;
      step();
      check("midrst_exec", 32'(o_mem_exec), 32'd0);
      check("midrst_count", 32'(o_count), 32'd0);
      step();
      i_reset = 1'b0;
      wait_exec(1'b1, 10, "restart_exec");
      check("restart_addr", o_mem_addr, RESET_PC);

      // Randomised traffic.
      repeat (1500) begin
         i_ready       = 1'($urandom_range(0, 1));
         i_enable      = ($urandom_range(0, 9) != 0);
         i_mem_busy    = ($urandom_range(0, 4) == 0);
         lat           = $urandom_range(1, 4);
         i_redirect    = ($urandom_range(0, 39) == 0);
         i_redirect_pc = $urandom;
         step();
      end
      i_redirect = 1'b0;
      i_enable   = 1'b0;
      i_mem_busy = 1'b0;
      i_ready    = 1'b1;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
